// File: rtl/hc_stream_rmw.sv
// Streaming CCI-P read/modify/write engine: N source lines -> 32-bit lane op -> same index in dst, then a DSM status line.
// >=3 cycles rdvalid->write; reads gated by c0 almfull and credits, writes/DSM by c1 almfull; HC_STREAM_RMW_PERF_EN adds a cycle counter.

module hc_stream_rmw_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    output logic [W-1:0]             pop_dat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign pop_dat = mem[rd_ptr];
    assign empty   = (count == '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module hc_stream_rmw #(
    parameter int ADDR_W          = 42,
    parameter int CNT_W           = 16,
    parameter int MAX_OUTSTANDING = 8,
    parameter int FIFO_DEPTH      = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] cfg_src_addr,
    input  logic [ADDR_W-1:0] cfg_dst_addr,
    input  logic [ADDR_W-1:0] cfg_dsm_addr,
    input  logic [CNT_W-1:0]  cfg_num_lines,
    input  logic [1:0]        cfg_op,
    input  logic [31:0]       cfg_operand,
    output logic              busy,
    output logic              done,
    output logic              c0_tx_valid,
    output logic [ADDR_W-1:0] c0_tx_addr,
    output logic [15:0]       c0_tx_mdata,
    input  logic              c0_tx_almfull,
    input  logic              c0_rx_rdvalid,
    input  logic [15:0]       c0_rx_mdata,
    input  logic [511:0]      c0_rx_data,
    output logic              c1_tx_valid,
    output logic [ADDR_W-1:0] c1_tx_addr,
    output logic              c1_tx_sop,
    output logic [511:0]      c1_tx_data,
    input  logic              c1_tx_almfull,
    input  logic              c1_rx_wrvalid
);
    localparam int IW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int FAW = $clog2(FIFO_DEPTH);
    localparam int EW  = 512 + CNT_W;

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_DSM, S_DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [ADDR_W-1:0] dsm_q;
    logic [CNT_W-1:0]  num_q;
    logic [1:0]        op_q;
    logic [31:0]       operand_q;
    logic [CNT_W-1:0]  rd_issued;
    logic [CNT_W-1:0]  wr_acked;
    logic [IW-1:0]     inflight;

    logic              res_vld;
    logic [511:0]      res_dat;
    logic [CNT_W-1:0]  res_tag;

    logic [EW-1:0]     fifo_out;
    logic [FAW:0]      fifo_count;
    logic              fifo_empty;

    logic              active;
    logic              rsp_take;
    logic              rd_issue;
    logic              wr_issue;
    logic              dsm_issue;
    logic [63:0]       perf_val;

    function automatic logic [511:0] lane_op(input logic [511:0] d, input logic [1:0] op,
                                             input logic [31:0] k);
        logic [511:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            case (op)
                2'd0:    r[32*i +: 32] = d[32*i +: 32] + k;
                2'd1:    r[32*i +: 32] = d[32*i +: 32] - k;
                2'd2:    r[32*i +: 32] = d[32*i +: 32] ^ k;
                default: r[32*i +: 32] = d[32*i +: 32];
            endcase
        end
        return r;
    endfunction

    assign active   = (state == S_RUN) || (state == S_DRAIN);
    assign rsp_take = c0_rx_rdvalid && active;

    // The staged result counts against FIFO credit: it has left inflight but not yet entered the FIFO.
    assign rd_issue = (state == S_RUN) && !c0_tx_almfull && (rd_issued < num_q)
                   && (int'(inflight) < MAX_OUTSTANDING)
                   && ((int'(inflight) + int'(fifo_count) + int'(res_vld)) < FIFO_DEPTH);

    assign wr_issue  = active && !fifo_empty && !c1_tx_almfull;
    assign dsm_issue = (state == S_DSM) && !c1_tx_almfull;

    hc_stream_rmw_fifo #(
        .W     (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (res_vld),
        .push_dat ({res_tag, res_dat}),
        .pop      (wr_issue),
        .pop_dat  (fifo_out),
        .count    (fifo_count),
        .empty    (fifo_empty)
    );

`ifdef HC_STREAM_RMW_PERF_EN
    logic [63:0] perf_cyc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_cyc <= '0;
        end else if ((state == S_IDLE) && start) begin
            perf_cyc <= '0;
        end else if (active || (state == S_DSM)) begin
            perf_cyc <= perf_cyc + 64'd1;
        end
    end

    assign perf_val = perf_cyc;
`else
    assign perf_val = '0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            src_q       <= '0;
            dst_q       <= '0;
            dsm_q       <= '0;
            num_q       <= '0;
            op_q        <= '0;
            operand_q   <= '0;
            rd_issued   <= '0;
            wr_acked    <= '0;
            inflight    <= '0;
            res_vld     <= 1'b0;
            res_dat     <= '0;
            res_tag     <= '0;
            c0_tx_valid <= 1'b0;
            c0_tx_addr  <= '0;
            c0_tx_mdata <= '0;
            c1_tx_valid <= 1'b0;
            c1_tx_addr  <= '0;
            c1_tx_sop   <= 1'b0;
            c1_tx_data  <= '0;
        end else begin
            c0_tx_valid <= rd_issue;
            if (rd_issue) begin
                c0_tx_addr  <= src_q + ADDR_W'(rd_issued);
                c0_tx_mdata <= 16'(rd_issued);
                rd_issued   <= rd_issued + CNT_W'(1);
            end

            case ({rd_issue, rsp_take})
                2'b10:   inflight <= inflight + IW'(1);
                2'b01:   inflight <= inflight - IW'(1);
                default: inflight <= inflight;
            endcase

            res_vld <= rsp_take;
            if (rsp_take) begin
                res_dat <= lane_op(c0_rx_data, op_q, operand_q);
                res_tag <= c0_rx_mdata[CNT_W-1:0];
            end

            if (c1_rx_wrvalid && active) begin
                wr_acked <= wr_acked + CNT_W'(1);
            end

            c1_tx_valid <= wr_issue || dsm_issue;
            c1_tx_sop   <= wr_issue || dsm_issue;
            if (wr_issue) begin
                c1_tx_addr <= dst_q + ADDR_W'(fifo_out[EW-1 -: CNT_W]);
                c1_tx_data <= fifo_out[511:0];
            end else if (dsm_issue) begin
                c1_tx_addr <= dsm_q + ADDR_W'(1);
                c1_tx_data <= {384'd0, perf_val, 32'(num_q), 32'd1};
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        src_q     <= cfg_src_addr;
                        dst_q     <= cfg_dst_addr;
                        dsm_q     <= cfg_dsm_addr;
                        num_q     <= cfg_num_lines;
                        op_q      <= cfg_op;
                        operand_q <= cfg_operand;
                        rd_issued <= '0;
                        wr_acked  <= '0;
                        busy      <= 1'b1;
                        state     <= (cfg_num_lines == '0) ? S_DSM : S_RUN;
                    end
                end
                S_RUN: begin
                    if (rd_issued == num_q) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if ((wr_acked == num_q) && fifo_empty && !res_vld) begin
                        state <= S_DSM;
                    end
                end
                S_DSM: begin
                    if (dsm_issue) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (stop) begin
                        state <= S_IDLE;
                        done  <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
